// File: rtl/dsp_accum_pkg.sv
// Shared types and constants for the product accumulator: FSM state encoding
// and the width of the beat counter.
package dsp_accum_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/dsp_accum_if.sv
// Product-in / frame-sum-out stream bundle for dsp_accum, plus the FSM state tap.
// Handshake: a beat or result moves on a rising clk edge where valid && ready;
// the producer holds its payload stable while valid is high and ready is low.
interface dsp_accum_if
    import dsp_accum_pkg::*;
#(
    parameter int P_WIDTH   = 4,
    parameter int ACC_WIDTH = 16
) ();

    logic                 in_valid;
    logic [P_WIDTH-1:0]   in_data;
    logic                 in_last;
    logic                 in_ready;
    logic                 out_valid;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_sat;
    logic                 out_ready;
    logic [CNT_W-1:0]     out_count;
    state_t               dbg_state;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_count, dbg_state
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_count, dbg_state
    );

endinterface

// File: rtl/dsp_sat_add.sv
// Combinational saturating adder: signed mode clamps to [min, max] of WIDTH bits,
// unsigned mode clamps at all-ones. ovf flags any clamp.
module dsp_sat_add #(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH:0] raw;

    if (SIGNED != 0) begin : g_signed
        // One guard bit: top two bits disagree exactly when the true sum left range.
        always_comb begin
            raw = {a[WIDTH-1], a} + {b[WIDTH-1], b};
            ovf = raw[WIDTH] ^ raw[WIDTH-1];
            sum = raw[WIDTH-1:0];
            if (ovf) begin
                sum = raw[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
    end else begin : g_unsigned
        always_comb begin
            raw = {1'b0, a} + {1'b0, b};
            ovf = raw[WIDTH];
            sum = raw[WIDTH-1:0];
            if (ovf) begin
                sum = {WIDTH{1'b1}};
            end
        end
    end

endmodule

// File: rtl/dsp_accum.sv
// Frame accumulator for multiplier products: sums up to LEN beats (or until in_last)
// with saturation, then holds the result until the downstream takes it.
module dsp_accum
    import dsp_accum_pkg::*;
#(
    parameter int P_WIDTH   = 4,
    parameter int ACC_WIDTH = 16,
    parameter int LEN       = 4,
    parameter int SIGNED    = 1
) (
    input logic        clk,
    input logic        reset,
    dsp_accum_if.slave bus
);

    if (ACC_WIDTH < P_WIDTH + 1) begin : g_bad_acc_width
        $error("dsp_accum: ACC_WIDTH must be at least P_WIDTH+1");
    end
    if (LEN < 1 || LEN > 65535) begin : g_bad_len
        $error("dsp_accum: LEN must be in 1..65535");
    end

    state_t               state, state_n;
    logic [ACC_WIDTH-1:0] acc, acc_n, ext_data, add_sum, beat_acc;
    logic [ACC_WIDTH-1:0] od_q, od_n;
    logic [CNT_W-1:0]     cnt, cnt_n, beat_cnt, oc_q, oc_n;
    logic                 sat, sat_n, beat_sat, add_ovf;
    logic                 ov_q, ov_n, os_q, os_n;
    logic                 rdy_en, in_ready, accept, final_beat;

    assign ext_data = {{(ACC_WIDTH-P_WIDTH){(SIGNED != 0) && bus.in_data[P_WIDTH-1]}}, bus.in_data};

    dsp_sat_add #(
        .WIDTH  (ACC_WIDTH),
        .SIGNED (SIGNED)
    ) u_add (
        .a   (acc),
        .b   (ext_data),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // rdy_en keeps in_ready low through reset and until the first edge after release.
    assign in_ready = rdy_en && (state != HOLD);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        beat_acc = add_sum;
        beat_cnt = cnt + CNT_W'(1);
        beat_sat = sat | add_ovf;
        if (state == IDLE) begin
            beat_acc = ext_data;
            beat_cnt = CNT_W'(1);
            beat_sat = 1'b0;
        end
        final_beat = bus.in_last || (beat_cnt == CNT_W'(LEN));
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        sat_n   = sat;
        ov_n    = ov_q;
        od_n    = od_q;
        os_n    = os_q;
        oc_n    = oc_q;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_n   = beat_acc;
                    cnt_n   = beat_cnt;
                    sat_n   = beat_sat;
                    state_n = ACCUM;
                    if (final_beat) begin
                        state_n = HOLD;
                        ov_n    = 1'b1;
                        od_n    = beat_acc;
                        os_n    = beat_sat;
                        oc_n    = beat_cnt;
                    end
                end
            end
            HOLD: begin
                if (ov_q && bus.out_ready) begin
                    ov_n    = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            sat    <= 1'b0;
            ov_q   <= 1'b0;
            od_q   <= '0;
            os_q   <= 1'b0;
            oc_q   <= '0;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            sat    <= sat_n;
            ov_q   <= ov_n;
            od_q   <= od_n;
            os_q   <= os_n;
            oc_q   <= oc_n;
            rdy_en <= 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_sat   = os_q;
    assign bus.out_count = oc_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_dsp_accum.sv
// Directed bench for dsp_accum across three configurations (default, narrow
// accumulator, unsigned single-beat frames) with a reference-model scoreboard.
module tb_dsp_accum;
    import dsp_accum_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dsp_accum_if #(.P_WIDTH(4), .ACC_WIDTH(16)) i0 ();
    dsp_accum_if #(.P_WIDTH(4), .ACC_WIDTH(5))  i1 ();
    dsp_accum_if #(.P_WIDTH(4), .ACC_WIDTH(16)) i2 ();

    dsp_accum #(.P_WIDTH(4), .ACC_WIDTH(16), .LEN(4), .SIGNED(1))
        u0 (.clk(clk), .reset(reset), .bus(i0.slave));
    dsp_accum #(.P_WIDTH(4), .ACC_WIDTH(5), .LEN(4), .SIGNED(1))
        u1 (.clk(clk), .reset(reset), .bus(i1.slave));
    dsp_accum #(.P_WIDTH(4), .ACC_WIDTH(16), .LEN(1), .SIGNED(0))
        u2 (.clk(clk), .reset(reset), .bus(i2.slave));

    int total = 0;
    int bad   = 0;

    // Scoreboard entry: {instance[1:0], sat, count[15:0], data[15:0]}
    logic [34:0] exp_q[$];

    int     cfg_w[3]   = '{16, 5, 16};
    int     cfg_len[3] = '{4, 4, 1};
    bit     cfg_sgn[3] = '{1'b1, 1'b1, 1'b0};
    longint m_acc[3];
    int     m_cnt[3];
    bit     m_sat[3];
    int     last_acc_cyc;

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- DUT access helpers ----------------
    task automatic drive(input int k, input logic v, input logic [3:0] d, input logic l);
        case (k)
            0: begin i0.in_valid = v; i0.in_data = d; i0.in_last = l; end
            1: begin i1.in_valid = v; i1.in_data = d; i1.in_last = l; end
            default: begin i2.in_valid = v; i2.in_data = d; i2.in_last = l; end
        endcase
    endtask

    task automatic idle(input int k);
        drive(k, 1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    endtask

    task automatic set_ordy(input int k, input logic r);
        case (k)
            0: i0.out_ready = r;
            1: i1.out_ready = r;
            default: i2.out_ready = r;
        endcase
    endtask

    function automatic logic rdy(input int k);
        case (k)
            0: return i0.in_ready;
            1: return i1.in_ready;
            default: return i2.in_ready;
        endcase
    endfunction

    function automatic logic ovalid(input int k);
        case (k)
            0: return i0.out_valid;
            1: return i1.out_valid;
            default: return i2.out_valid;
        endcase
    endfunction

    function automatic logic oready(input int k);
        case (k)
            0: return i0.out_ready;
            1: return i1.out_ready;
            default: return i2.out_ready;
        endcase
    endfunction

    function automatic logic [15:0] odata(input int k);
        case (k)
            0: return i0.out_data;
            1: return {11'b0, i1.out_data};
            default: return i2.out_data;
        endcase
    endfunction

    function automatic logic osat(input int k);
        case (k)
            0: return i0.out_sat;
            1: return i1.out_sat;
            default: return i2.out_sat;
        endcase
    endfunction

    function automatic logic [15:0] ocount(input int k);
        case (k)
            0: return i0.out_count;
            1: return i1.out_count;
            default: return i2.out_count;
        endcase
    endfunction

    // ---------------- reference model ----------------
    function automatic void model_beat(input int k, input logic [3:0] d, input logic l);
        longint x, mx, mn, s;
        int w;
        w = cfg_w[k];
        x = cfg_sgn[k] ? longint'($signed(d)) : longint'(d);
        if (cfg_sgn[k]) begin
            mx = (longint'(1) << (w - 1)) - 1;
            mn = -(longint'(1) << (w - 1));
        end else begin
            mx = (longint'(1) << w) - 1;
            mn = 0;
        end
        if (m_cnt[k] == 0) begin
            m_acc[k] = x;
            m_cnt[k] = 1;
            m_sat[k] = 1'b0;
        end else begin
            s = m_acc[k] + x;
            if (s > mx) begin s = mx; m_sat[k] = 1'b1; end
            if (s < mn) begin s = mn; m_sat[k] = 1'b1; end
            m_acc[k] = s;
            m_cnt[k] = m_cnt[k] + 1;
        end
        if (l || m_cnt[k] == cfg_len[k]) begin
            exp_q.push_back({2'(k), m_sat[k], 16'(m_cnt[k]),
                             16'(m_acc[k] & ((longint'(1) << w) - 1))});
            m_cnt[k] = 0;
        end
    endfunction

    // Offer a beat until accepted (bounded), then feed the model.
    task automatic send(input int k, input logic [3:0] d, input logic l);
        int waited = 0;
        drive(k, 1'b1, d, l);
        while (!rdy(k) && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("in_ready_wait", 35'(rdy(k)), 35'd1);
        if (rdy(k)) begin
            @(posedge clk); #1;
            last_acc_cyc = cyc;
            model_beat(k, d, l);
        end
    endtask

    task automatic chk_out(input string tag, input int k, input logic [15:0] d,
                           input logic s, input logic [15:0] c);
        chk({tag, "_valid"}, 35'(ovalid(k)), 35'd1);
        chk({tag, "_data"},  35'(odata(k)),  35'(d));
        chk({tag, "_sat"},   35'(osat(k)),   35'(s));
        chk({tag, "_count"}, 35'(ocount(k)), 35'(c));
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            for (int k = 0; k < 3; k++) begin
                if (ovalid(k) && oready(k)) begin
                    total++;
                    assert (exp_q.size() > 0) else begin
                        bad++;
                        $error("FAIL out_unexpected: inst %0d observed data %0h expected no result",
                               k, odata(k));
                    end
                    if (exp_q.size() > 0) begin
                        chk("scoreboard", {2'(k), osat(k), ocount(k), odata(k)}, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, a1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle(k);
            set_ordy(k, 1'b1);
            m_cnt[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  35'(i0.in_ready),  35'd0);
        chk("rst_out_valid", 35'(i0.out_valid), 35'd0);
        chk("rst_out_data",  35'(i0.out_data),  35'd0);
        chk("rst_out_count", 35'(i0.out_count), 35'd0);
        chk("rst_out_sat",   35'(i0.out_sat),   35'd0);
        chk("rst_state",     35'(i0.dbg_state), 35'(IDLE));
        reset = 1'b1;
        #1;
        chk("rel_in_ready_low", 35'(i0.in_ready), 35'd0);
        @(posedge clk); #1;
        chk("rel_in_ready_high", 35'(i0.in_ready), 35'd1);

        // Full-length frame with a negative product
        send(0, 4'h3, 1'b0);
        send(0, 4'h5, 1'b0);
        send(0, 4'hE, 1'b0);
        send(0, 4'h1, 1'b0);
        idle(0);
        chk_out("len4", 0, 16'd7, 1'b0, 16'd4);
        chk("len4_hold_ready", 35'(i0.in_ready), 35'd0);
        chk("len4_hold_state", 35'(i0.dbg_state), 35'(HOLD));
        @(posedge clk); #1;
        chk("len4_after_valid", 35'(i0.out_valid), 35'd0);
        chk("len4_after_ready", 35'(i0.in_ready), 35'd1);

        // Early close via in_last, then a fresh one-beat frame
        send(0, 4'h2, 1'b0);
        send(0, 4'h4, 1'b1);
        idle(0);
        chk_out("last", 0, 16'd6, 1'b0, 16'd2);
        send(0, 4'h5, 1'b1);
        idle(0);
        chk_out("fresh", 0, 16'd5, 1'b0, 16'd1);

        // Random frames, checked by the scoreboard only
        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int b = 0; b < n; b++) begin
                send(0, 4'($urandom_range(0, 15)), 1'(b == n - 1));
            end
            idle(0);
        end

        // Back-pressure: result held, new beats refused
        send(0, 4'h1, 1'b0);
        send(0, 4'h2, 1'b0);
        set_ordy(0, 1'b0);
        send(0, 4'h3, 1'b0);
        send(0, 4'h4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 4'h9, 1'b1);
            chk("bp_valid", 35'(i0.out_valid), 35'd1);
            chk("bp_data",  35'(i0.out_data),  35'd10);
            chk("bp_ready", 35'(i0.in_ready),  35'd0);
            @(posedge clk); #1;
        end
        set_ordy(0, 1'b1);
        t0 = cyc;
        send(0, 4'h6, 1'b1);
        idle(0);
        chk("bp_accept_gap", 35'(last_acc_cyc - t0), 35'd2);
        chk_out("bp_next", 0, 16'd6, 1'b0, 16'd1);
        @(posedge clk); #1;

        // Reset mid-frame discards the partial sum
        send(0, 4'h7, 1'b0);
        send(0, 4'h7, 1'b0);
        idle(0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        #2;
        chk("midrst_valid", 35'(i0.out_valid), 35'd0);
        chk("midrst_ready", 35'(i0.in_ready),  35'd0);
        chk("midrst_state", 35'(i0.dbg_state), 35'(IDLE));
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_valid2", 35'(i0.out_valid), 35'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send(0, 4'h1, 1'b0);
        idle(0);
        chk_out("postrst", 0, 16'd4, 1'b0, 16'd4);
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_quiet", 35'(i0.out_valid), 35'd0);

        // Narrow accumulator saturation, both directions and recovery
        for (int i = 0; i < 4; i++) send(1, 4'h7, 1'b0);
        idle(1);
        chk_out("sat_hi", 1, 16'h000F, 1'b1, 16'd4);
        for (int i = 0; i < 4; i++) send(1, 4'h8, 1'b0);
        idle(1);
        chk_out("sat_lo", 1, 16'h0010, 1'b1, 16'd4);
        send(1, 4'h7, 1'b0);
        send(1, 4'h7, 1'b0);
        send(1, 4'h7, 1'b0);
        send(1, 4'h8, 1'b0);
        idle(1);
        chk_out("sat_cont", 1, 16'h0007, 1'b1, 16'd4);
        send(1, 4'h1, 1'b0);
        send(1, 4'h2, 1'b0);
        send(1, 4'h3, 1'b0);
        send(1, 4'hF, 1'b0);
        idle(1);
        chk_out("sat_clear", 1, 16'h0005, 1'b0, 16'd4);

        // Unsigned, one beat per frame: one bubble between accepts
        @(posedge clk); #1;
        send(2, 4'hF, 1'b0);
        a1 = last_acc_cyc;
        chk_out("len1_a", 2, 16'd15, 1'b0, 16'd1);
        send(2, 4'h3, 1'b0);
        idle(2);
        chk("len1_gap", 35'(last_acc_cyc - a1), 35'd2);
        chk_out("len1_b", 2, 16'd3, 1'b0, 16'd1);

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drain", 35'(exp_q.size()), 35'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
